// File: rtl/stream_split.sv
// stream_split: fans one wide word of N_LINKS lanes out into N_LINKS independent
// AXI-Stream masters. Each lane has its own small FIFO, so a stalled consumer only
// drops its own words and never stalls or misaligns the other lanes.
// Optional feature macro: STREAM_SPLIT_OVF_CNT_EN adds a saturating 16-bit drop
// counter per lane; without it, ovf_count is tied to zero.
module stream_split #(
    parameter int unsigned N_LINKS    = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clear,
    input  logic [N_LINKS*DATA_WIDTH-1:0]   data_in,
    input  logic                            data_in_valid,
    output logic [N_LINKS*DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [N_LINKS-1:0]              M_AXIS_TVALID,
    input  logic [N_LINKS-1:0]              M_AXIS_TREADY,
    output logic [N_LINKS-1:0]              ovf_flag,
    output logic [N_LINKS*16-1:0]           ovf_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    for (genvar i = 0; i < N_LINKS; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PtrW-1:0]       wptr_q;
        logic [PtrW-1:0]       rptr_q;
        logic [CntW-1:0]       count_q;
        logic                  ovf_flag_q;
        logic                  empty;
        logic                  full;
        logic                  pop;
        logic                  push;
        logic                  drop;

        assign empty = (count_q == '0);
        assign full  = (count_q == CntW'(FIFO_DEPTH));
        // A pop frees the slot in the same cycle, so a full lane still accepts.
        assign pop   = !empty && M_AXIS_TREADY[i];
        assign push  = data_in_valid && (!full || pop);
        assign drop  = data_in_valid && full && !pop;

        // Pointer, occupancy and sticky-flag state; clear outranks push and pop.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wptr_q     <= '0;
                rptr_q     <= '0;
                count_q    <= '0;
                ovf_flag_q <= 1'b0;
            end else if (clear) begin
                wptr_q     <= '0;
                rptr_q     <= '0;
                count_q    <= '0;
                ovf_flag_q <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + PtrW'(1);
                if (pop)  rptr_q <= rptr_q + PtrW'(1);
                if (push && !pop)      count_q <= count_q + CntW'(1);
                else if (pop && !push) count_q <= count_q - CntW'(1);
                if (drop) ovf_flag_q <= 1'b1;
            end
        end

        // Storage array; contents need no reset because occupancy gates visibility.
        always_ff @(posedge clk) begin
            if (push && !clear) mem[wptr_q] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end

        assign M_AXIS_TVALID[i] = !empty;
        // Forced to zero when empty so TDATA reads 0 after reset or clear.
        assign M_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH] = empty ? '0 : mem[rptr_q];
        assign ovf_flag[i] = ovf_flag_q;

`ifdef STREAM_SPLIT_OVF_CNT_EN
        logic [15:0] drop_cnt_q;

        // Saturating drop counter.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                drop_cnt_q <= '0;
            end else if (clear) begin
                drop_cnt_q <= '0;
            end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end

        assign ovf_count[i*16 +: 16] = drop_cnt_q;
`else
        assign ovf_count[i*16 +: 16] = '0;
`endif
    end

endmodule

// File: tb/tb_stream_split.sv
// tb_stream_split: directed steps with a per-lane queue scoreboard. Each step checks
// the DUT outputs against the model before the edge, then advances the model.
module tb_stream_split;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic             clk;
    logic             rstn;
    logic             clear;
    logic [N*W-1:0]   data_in;
    logic             data_in_valid;
    logic [N*W-1:0]   tdata;
    logic [N-1:0]     tvalid;
    logic [N-1:0]     tready;
    logic [N-1:0]     ovf_flag;
    logic [N*16-1:0]  ovf_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [N][$];
    logic [N-1:0] mflag;
    logic [15:0]  mcnt [N];

    stream_split #(
        .N_LINKS    (N),
        .DATA_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .clear         (clear),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .ovf_flag      (ovf_flag),
        .ovf_count     (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            mcnt[i] = '0;
        end
        mflag = '0;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            check($sformatf("tvalid[%0d]", i), 32'(tvalid[i]), 32'(mq[i].size() != 0));
            if (mq[i].size() != 0)
                check($sformatf("tdata[%0d]", i), 32'(tdata[i*W +: W]), 32'(mq[i][0]));
            else
                check($sformatf("tdata_idle[%0d]", i), 32'(tdata[i*W +: W]), 32'h0);
            check($sformatf("ovf_count[%0d]", i), 32'(ovf_count[i*16 +: 16]), 32'(mcnt[i]));
        end
        check("ovf_flag", 32'(ovf_flag), 32'(mflag));
    endtask

    // Drive one cycle: check current outputs, advance the model, take the edge.
    task automatic step(input logic v, input logic [N*W-1:0] d, input logic [N-1:0] rdy,
                        input logic clr);
        data_in_valid = v;
        data_in       = d;
        tready        = rdy;
        clear         = clr;
        check_outputs();
        if (clr) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                int  sz;
                logic pop;
                sz  = mq[i].size();
                pop = (sz != 0) && rdy[i];
                if (pop) void'(mq[i].pop_front());
                if (v) begin
                    if (sz < D || pop) begin
                        mq[i].push_back(d[i*W +: W]);
                    end else begin
                        mflag[i] = 1'b1;
`ifdef STREAM_SPLIT_OVF_CNT_EN
                        if (mcnt[i] != 16'hFFFF) mcnt[i] = mcnt[i] + 16'd1;
`endif
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; clear = 1'b0; data_in = '0; data_in_valid = 1'b0; tready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tvalid", 32'(tvalid), 32'h0);
        check("reset_tdata", tdata, 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1: single push, one-cycle latency, single-cycle visibility
        step(1'b1, 32'h44332211, 4'hF, 1'b0);
        check("t1_tvalid", 32'(tvalid), 32'hF);
        check("t1_tdata", tdata, 32'h44332211);
        step(1'b0, '0, 4'hF, 1'b0);
        check("t1_tvalid_off", 32'(tvalid), 32'h0);
        step(1'b0, '0, 4'hF, 1'b0);

        // 2: lane 2 back-pressured, fifth word dropped there only
        for (int k = 1; k <= 5; k++) step(1'b1, {4{8'(k)}}, 4'b1011, 1'b0);
        check("t2_flag", 32'(ovf_flag), 32'h4);
`ifdef STREAM_SPLIT_OVF_CNT_EN
        check("t2_cnt2", 32'(ovf_count[47:32]), 32'h1);
`else
        check("t2_cnt2", 32'(ovf_count[47:32]), 32'h0);
`endif
        check("t2_head2", 32'(tdata[23:16]), 32'h01);
        for (int k = 0; k < 5; k++) step(1'b0, '0, 4'hF, 1'b0);
        check("t2_drained", 32'(tvalid), 32'h0);

        // 3: full lane with simultaneous pop accepts the push
        step(1'b0, '0, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, {4{8'(8'h10 + k)}}, 4'h0, 1'b0);
        step(1'b1, 32'hAAAAAAAA, 4'hF, 1'b0);
        check("t3_flag", 32'(ovf_flag), 32'h0);
        check("t3_head", tdata, 32'h11111111);
        for (int k = 0; k < 5; k++) step(1'b0, '0, 4'hF, 1'b0);

        // 4: stalled head stays put while pushes continue
        step(1'b1, 32'h5A5A5A5A, 4'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, {4{8'(8'hC0 + k)}}, 4'h0, 1'b0);
            check("t4_stable", tdata, 32'h5A5A5A5A);
        end

        // 5a: synchronous clear with lanes full and flags set
        step(1'b0, '0, 4'h0, 1'b1);
        check("t5_clr_tvalid", 32'(tvalid), 32'h0);
        check("t5_clr_flag", 32'(ovf_flag), 32'h0);
        check("t5_clr_cnt", ovf_count, 64'h0);
        // 5b: asynchronous reset drops TVALID between edges
        for (int k = 0; k < 5; k++) step(1'b1, {4{8'(8'h30 + k)}}, 4'h0, 1'b0);
        data_in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("t5_rst_tvalid", 32'(tvalid), 32'h0);
        check("t5_rst_flag", 32'(ovf_flag), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b0, '0, 4'hF, 1'b0);
        step(1'b1, 32'h0D0C0B0A, 4'hF, 1'b0);
        step(1'b0, '0, 4'hF, 1'b0);

`ifdef STREAM_SPLIT_OVF_CNT_EN
        // 6: drop counter saturates
        for (int k = 0; k < 70000; k++) step(1'b1, 32'(k), 4'b1110, 1'b0);
        check("t6_sat", 32'(ovf_count[15:0]), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
